// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with per-frame
// snapshot of the BCD time digits, blink blanking and dash for bad codes.
module seg_scan_driver #(
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [2:0] min_hi,
  input  logic [3:0] min_lo,
  input  logic [2:0] sec_hi,
  input  logic [3:0] sec_lo,
  input  logic       blink_min,
  input  logic       blink_sec,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int unsigned   CW       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_TICKS - 1);

  logic [1:0]    idx;
  logic [1:0]    nidx;
  logic [2:0]    sh_min_hi;
  logic [3:0]    sh_min_lo;
  logic [2:0]    sh_sec_hi;
  logic [3:0]    sh_sec_lo;
  logic [CW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic          blank;

  // Select and decode the digit for the slot being entered on this strobe.
  // Slot 0 is entered at frame start, when the shadows are being loaded on
  // the same edge, so it reads the live sec_lo input instead of the shadow.
  always_comb begin
    nidx  = idx + 2'd1;
    digit = '0;
    case (nidx)
      2'd0: digit = sec_lo;
      2'd1: digit = {1'b0, sh_sec_hi};
      2'd2: digit = sh_min_lo;
      2'd3: digit = {1'b0, sh_min_hi};
      default: digit = '0;
    endcase
    case (digit)
      4'd0: seg_dec = 7'h40;
      4'd1: seg_dec = 7'h79;
      4'd2: seg_dec = 7'h24;
      4'd3: seg_dec = 7'h30;
      4'd4: seg_dec = 7'h19;
      4'd5: seg_dec = 7'h12;
      4'd6: seg_dec = 7'h02;
      4'd7: seg_dec = 7'h78;
      4'd8: seg_dec = 7'h00;
      4'd9: seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
    blank = blink_phase & (nidx[1] ? blink_min : blink_sec);
  end

  // Scan index and registered segment/anode outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd3;
      seg <= '1;
      an  <= '1;
    end else if (scan_en) begin
      idx <= nidx;
      seg <= {(nidx != 2'd2), seg_dec};
      an  <= blank ? 4'b1111 : ~(4'b0001 << nidx);
    end
  end

  // Frame snapshot of the four digits, taken when wrapping to slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_min_hi <= '0;
      sh_min_lo <= '0;
      sh_sec_hi <= '0;
      sh_sec_lo <= '0;
    end else if (scan_en && idx == 2'd3) begin
      sh_min_hi <= min_hi;
      sh_min_lo <= min_lo;
      sh_sec_hi <= sec_hi;
      sh_sec_lo <= sec_lo;
    end
  end

  // Free-running blink half-period counter and phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (scan_en) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver: table vectors, hand-written corner cases
// and randomized traffic against a behavioural model.
module tb_seg_scan_driver;

  localparam int unsigned BT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_en = 1'b0;
  logic [2:0] min_hi = '0;
  logic [3:0] min_lo = '0;
  logic [2:0] sec_hi = '0;
  logic [3:0] sec_lo = '0;
  logic       blink_min = 1'b0;
  logic       blink_sec = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en),
    .min_hi(min_hi), .min_lo(min_lo), .sec_hi(sec_hi), .sec_lo(sec_lo),
    .blink_min(blink_min), .blink_sec(blink_sec),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Behavioural model: position in the frame and blink phase are derived
  // from the number of strobes since reset with plain arithmetic.
  localparam logic [7:0] DEC [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         m_t;
  int         m_sh [4];
  logic [7:0] m_seg;
  logic [3:0] m_an;

  function automatic logic [7:0] dec(input int d);
    return (d > 9) ? 8'hBF : DEC[d];
  endfunction

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < 4; i++) m_sh[i] = 0;
    m_seg = 8'hFF;
    m_an  = 4'hF;
  endtask

  task automatic model_step();
    int  slot;
    int  phase;
    bit  blank;
    slot  = m_t % 4;
    phase = (m_t / BT) % 2;
    if (slot == 0) begin
      m_sh[0] = sec_lo; m_sh[1] = sec_hi; m_sh[2] = min_lo; m_sh[3] = min_hi;
    end
    m_seg = dec(m_sh[slot]);
    if (slot == 2) m_seg[7] = 1'b0;
    blank = (phase == 1) && ((slot >= 2) ? blink_min : blink_sec);
    m_an  = blank ? 4'hF : ~(4'b0001 << slot);
    m_t++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    scan_en = 1'b1;
    @(posedge clk);
    #1 scan_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic set_digits(input int mh, input int ml, input int sh, input int sl);
    min_hi = 3'(mh); min_lo = 4'(ml); sec_hi = 3'(sh); sec_lo = 4'(sl);
  endtask

  typedef struct {
    bit         do_rst;
    int         mh, ml, sh, sl;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 3, 7, 5, 9, 4'hE, 8'h90};
    vecs[1] = '{1'b0, 3, 7, 5, 9, 4'hD, 8'h92};
    vecs[2] = '{1'b0, 3, 7, 5, 9, 4'hB, 8'h78};
    vecs[3] = '{1'b0, 3, 7, 5, 9, 4'h7, 8'hB0};
    vecs[4] = '{1'b0, 3, 7, 5, 9, 4'hE, 8'h90};
    vecs[5] = '{1'b1, 0, 12, 0, 15, 4'hE, 8'hBF};
    vecs[6] = '{1'b0, 0, 12, 0, 15, 4'hD, 8'hC0};
    vecs[7] = '{1'b0, 0, 12, 0, 15, 4'hB, 8'h3F};
    vecs[8] = '{1'b0, 0, 12, 0, 15, 4'h7, 8'hC0};
    vecs[9] = '{1'b0, 7, 10, 6, 9, 4'hE, 8'h90};

    model_reset();
    #2;

    // Reset state and hold with scan_en idle
    do_reset();
    chk("reset_seg", seg, 8'hFF);
    chk("reset_an", {4'h0, an}, 8'h0F);
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(posedge clk);
      #1;
      chk("idle_seg", seg, 8'hFF);
      chk("idle_an", {4'h0, an}, 8'h0F);
    end

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) do_reset();
      set_digits(vecs[i].mh, vecs[i].ml, vecs[i].sh, vecs[i].sl);
      tick();
      chk($sformatf("vec%0d_an", i), {4'h0, an}, {4'h0, vecs[i].exp_an});
      chk($sformatf("vec%0d_seg", i), seg, vecs[i].exp_seg);
      // outputs must hold between strobes
      repeat (3) @(posedge clk);
      #1 chk($sformatf("vec%0d_hold", i), seg, vecs[i].exp_seg);
    end

    // Tearing: change min_hi mid-frame
    do_reset();
    set_digits(3, 7, 5, 9);
    tick();
    min_hi = 3'd1;
    tick(); tick(); tick();
    chk("tear_same_frame_seg", seg, 8'hB0);
    chk("tear_same_frame_an", {4'h0, an}, 8'h07);
    repeat (4) tick();
    chk("tear_next_frame_seg", seg, 8'hF9);

    // Blink minutes with BLINK_TICKS=4 over 16 strobes
    do_reset();
    set_digits(3, 7, 5, 9);
    blink_min = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] e_an;
      int s;
      tick();
      s = (k - 1) % 4;
      e_an = (s >= 2 && ((k - 1) / 4) % 2 == 1) ? 4'hF : ~(4'b0001 << s);
      chk($sformatf("blink_an_t%0d", k), {4'h0, an}, {4'h0, e_an});
      chk($sformatf("blink_seg_t%0d", k), seg, m_seg);
    end
    blink_min = 1'b0;

    // Asynchronous reset mid-clock during idx 1
    do_reset();
    blink_sec = 1'b1;
    set_digits(2, 4, 1, 8);
    tick(); tick(); tick();
    tick(); tick(); tick();   // idx 1, blink phase now 1
    #3 rst = 1'b1;
    #1;
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_an", {4'h0, an}, 8'h0F);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    sec_lo = 4'd4;
    tick();
    chk("post_rst_an", {4'h0, an}, 8'h0E);
    chk("post_rst_seg", seg, 8'h99);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("post_rst_blink_an_t%0d", k), {4'h0, an}, {4'h0, m_an});
    end
    blink_sec = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        min_hi = 3'($urandom_range(0, 7));
        min_lo = 4'($urandom_range(0, 15));
        sec_hi = 3'($urandom_range(0, 7));
        sec_lo = 4'($urandom_range(0, 15));
      end else begin
        min_hi = 3'($urandom_range(0, 5));
        min_lo = 4'($urandom_range(0, 9));
        sec_hi = 3'($urandom_range(0, 5));
        sec_lo = 4'($urandom_range(0, 9));
      end
      blink_min = 1'($urandom_range(0, 1));
      blink_sec = 1'($urandom_range(0, 1));
      tick();
      chk("rand_an", {4'h0, an}, {4'h0, m_an});
      chk("rand_seg", seg, m_seg);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("rand_hold_seg", seg, m_seg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
